// File: rtl/vga_sync_receiver.sv
`default_nettype none
// ============================================================================
// Module   : vga_sync_receiver
// Purpose  : Receive side of the 640x480@60 VGA output. Samples hs/vs/RGB at
//            pixel rate and measures line/frame timing against the expected
//            mode. It declares lock after LOCK_FRAMES clean frames. While
//            locked it recovers active-pixel coordinates, a data-enable and
//            the pixel colour.
// Ports    : clk, rst          - clock, synchronous active-high reset
//            pix_ce            - pixel-rate sample enable
//            vga_hs, vga_vs    - active-low syncs
//            vga_r/g/b         - 4-bit colour components
//            de, px_x, px_y    - active pixel valid and its coordinates
//            px_rgb            - {r,g,b} of the last active pixel
//            frame_start       - one-clk pulse per vsync falling edge
//            locked, err_cnt   - timing lock, saturating locked-error count
//            frame_crc, crc_valid (VGA_RX_CRC_EN only) - per-frame CRC-16
// Options  : define VGA_RX_CRC_EN to add the CRC-16-CCITT frame checksum.
// Revision : 1.0 - initial release
// ============================================================================
module vga_sync_receiver #(
    parameter int H_TOTAL     = 800,
    parameter int H_SYNC      = 96,
    parameter int H_BACK      = 52,
    parameter int H_ACTIVE    = 640,
    parameter int V_TOTAL     = 521,
    parameter int V_SYNC      = 2,
    parameter int V_BACK      = 28,
    parameter int V_ACTIVE    = 480,
    parameter int LOCK_FRAMES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pix_ce,
    input  logic        vga_hs,
    input  logic        vga_vs,
    input  logic [3:0]  vga_r,
    input  logic [3:0]  vga_g,
    input  logic [3:0]  vga_b,
    output logic        de,
    output logic [9:0]  px_x,
    output logic [9:0]  px_y,
    output logic [11:0] px_rgb,
    output logic        frame_start,
    output logic        locked,
    output logic [7:0]  err_cnt
`ifdef VGA_RX_CRC_EN
    ,
    output logic [15:0] frame_crc,
    output logic        crc_valid
`endif
);

    localparam logic [10:0] c_H_START = 11'(H_SYNC + H_BACK);
    localparam logic [10:0] c_H_END   = 11'(H_SYNC + H_BACK + H_ACTIVE);
    localparam logic [10:0] c_V_START = 11'(V_SYNC + V_BACK);
    localparam logic [10:0] c_V_END   = 11'(V_SYNC + V_BACK + V_ACTIVE);
    localparam logic [9:0]  c_H_OFF   = 10'(H_SYNC + H_BACK);
    localparam logic [9:0]  c_V_OFF   = 10'(V_SYNC + V_BACK);
    localparam logic [10:0] c_H_TOTAL = 11'(H_TOTAL);
    localparam logic [10:0] c_V_TOTAL = 11'(V_TOTAL);
    localparam logic [9:0]  c_H_SYNC  = 10'(H_SYNC);
    localparam logic [9:0]  c_V_SYNC  = 10'(V_SYNC);
    localparam logic [9:0]  c_CNT_MAX = 10'd1023;
    // Timeout threshold is clipped to what the saturating 10-bit counter can reach.
    localparam logic [9:0]  c_TIMEOUT = (2 * H_TOTAL - 1 > 1023) ? 10'd1023 : 10'(2 * H_TOTAL - 1);
    localparam int          c_GW      = $clog2(LOCK_FRAMES + 1);
    localparam logic [c_GW-1:0] c_LOCK     = c_GW'(LOCK_FRAMES);
    localparam logic [c_GW-1:0] c_GOOD_ONE = c_GW'(1);

    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_MEASURE = 2'd1,
        ST_LOCKED  = 2'd2
    } state_t;

    state_t            r_state, w_state_next;
    logic [c_GW-1:0]   r_good, w_good_next, w_good_inc;

    logic       r_hs_prev;   // last sampled hs
    logic       r_vs_prev;   // vs as sampled at the previous hs falling edge
    logic [9:0] r_h_cnt, r_hs_w, r_v_cnt, r_vs_w;
    logic       r_line_ok;   // a full line has elapsed since SEARCH entry
    logic       r_dirty;     // a line error occurred in the current frame

    logic       w_hs_fall, w_vs_edge, w_line_err, w_frame_err, w_timeout, w_any_err;
    logic [9:0] w_h_next, w_v_next;
    logic       w_in_window, w_de_next;

    assign w_hs_fall = pix_ce & r_hs_prev & ~vga_hs;
    assign w_vs_edge = w_hs_fall & r_vs_prev & ~vga_vs;

    assign w_h_next = w_hs_fall ? 10'd0 :
                      (r_h_cnt == c_CNT_MAX) ? c_CNT_MAX : r_h_cnt + 10'd1;
    assign w_v_next = !w_hs_fall ? r_v_cnt :
                      w_vs_edge ? 10'd0 :
                      (r_v_cnt == c_CNT_MAX) ? c_CNT_MAX : r_v_cnt + 10'd1;

    // The first line after SEARCH entry has no trustworthy start point, so it is not judged.
    assign w_line_err  = w_hs_fall & r_line_ok &
                         ((({1'b0, r_h_cnt} + 11'd1) != c_H_TOTAL) | (r_hs_w != c_H_SYNC));
    assign w_frame_err = w_vs_edge &
                         ((({1'b0, r_v_cnt} + 11'd1) != c_V_TOTAL) | (r_vs_w != c_V_SYNC));
    // Fires once, on the sample where h_cnt reaches the threshold.
    assign w_timeout   = pix_ce & ~w_hs_fall & (r_h_cnt == c_TIMEOUT - 10'd1);
    assign w_any_err   = w_line_err | w_frame_err | w_timeout;
    assign w_good_inc  = r_good + c_GOOD_ONE;

    always_comb begin
        w_state_next = r_state;
        w_good_next  = r_good;
        case (r_state)
            ST_SEARCH: begin
                if (w_vs_edge) begin
                    w_state_next = ST_MEASURE;
                    w_good_next  = '0;
                end
            end
            ST_MEASURE: begin
                if (w_timeout) begin
                    w_state_next = ST_SEARCH;
                end else if (w_line_err || w_frame_err) begin
                    w_good_next = '0;
                end else if (w_vs_edge) begin
                    if (r_dirty) begin
                        w_good_next = '0;
                    end else if (w_good_inc == c_LOCK) begin
                        w_state_next = ST_LOCKED;
                        w_good_next  = '0;
                    end else begin
                        w_good_next = w_good_inc;
                    end
                end
            end
            ST_LOCKED: begin
                if (w_any_err) begin
                    w_state_next = ST_SEARCH;
                end
            end
            default: w_state_next = ST_SEARCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_SEARCH;
            r_good  <= '0;
        end else begin
            r_state <= w_state_next;
            r_good  <= w_good_next;
        end
    end

    assign w_in_window = ({1'b0, w_h_next} >= c_H_START) && ({1'b0, w_h_next} < c_H_END) &&
                         ({1'b0, w_v_next} >= c_V_START) && ({1'b0, w_v_next} < c_V_END);
    assign w_de_next   = pix_ce && (w_state_next == ST_LOCKED) && w_in_window;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hs_prev   <= 1'b1;
            r_vs_prev   <= 1'b1;
            r_h_cnt     <= '0;
            r_hs_w      <= '0;
            r_v_cnt     <= '0;
            r_vs_w      <= '0;
            r_line_ok   <= 1'b0;
            r_dirty     <= 1'b0;
            de          <= 1'b0;
            px_x        <= '0;
            px_y        <= '0;
            px_rgb      <= '0;
            frame_start <= 1'b0;
            locked      <= 1'b0;
            err_cnt     <= '0;
        end else begin
            de          <= w_de_next;
            frame_start <= w_vs_edge;
            locked      <= (w_state_next == ST_LOCKED);

            if (pix_ce) begin
                r_hs_prev <= vga_hs;
                r_h_cnt   <= w_h_next;
                if (w_hs_fall) begin
                    r_hs_w <= 10'd1;
                end else if (!vga_hs && r_hs_w != c_CNT_MAX) begin
                    r_hs_w <= r_hs_w + 10'd1;
                end
            end

            if (w_hs_fall) begin
                r_vs_prev <= vga_vs;
                r_v_cnt   <= w_v_next;
                if (w_vs_edge) begin
                    r_vs_w <= 10'd1;
                end else if (!vga_vs && r_vs_w != c_CNT_MAX) begin
                    r_vs_w <= r_vs_w + 10'd1;
                end
            end

            if (w_state_next == ST_SEARCH && r_state != ST_SEARCH) begin
                r_line_ok <= 1'b0;
            end else if (w_hs_fall) begin
                r_line_ok <= 1'b1;
            end

            if (w_vs_edge) begin
                r_dirty <= 1'b0;
            end else if (w_line_err) begin
                r_dirty <= 1'b1;
            end

            if (w_de_next) begin
                px_x   <= w_h_next - c_H_OFF;
                px_y   <= w_v_next - c_V_OFF;
                px_rgb <= {vga_r, vga_g, vga_b};
            end

            // Only errors that break an established lock are counted.
            if (r_state == ST_LOCKED && w_any_err && err_cnt != 8'hFF) begin
                err_cnt <= err_cnt + 8'd1;
            end
        end
    end

`ifdef VGA_RX_CRC_EN
    // CRC-16-CCITT, MSB first, one 16-bit word per call.
    function automatic logic [15:0] f_crc16(input logic [15:0] crc_in, input logic [15:0] data);
        logic [15:0] crc;
        logic        fb;
        crc = crc_in;
        for (int i = 15; i >= 0; i--) begin
            fb  = crc[15] ^ data[i];
            crc = {crc[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
        end
        return crc;
    endfunction

    logic [15:0] r_crc_acc;
    logic        r_full_lock;   // lock held since the start of the current frame

    always_ff @(posedge clk) begin
        if (rst) begin
            r_crc_acc   <= 16'hFFFF;
            r_full_lock <= 1'b0;
            frame_crc   <= '0;
            crc_valid   <= 1'b0;
        end else begin
            crc_valid <= 1'b0;
            if (w_vs_edge) begin
                if (r_full_lock && r_state == ST_LOCKED && !w_any_err) begin
                    frame_crc <= r_crc_acc;
                    crc_valid <= 1'b1;
                end
                r_crc_acc   <= 16'hFFFF;
                r_full_lock <= (w_state_next == ST_LOCKED);
            end else begin
                if (w_de_next) begin
                    r_crc_acc <= f_crc16(r_crc_acc, {vga_r, vga_g, vga_b, 4'h0});
                end
                if (w_state_next != ST_LOCKED) begin
                    r_full_lock <= 1'b0;
                end
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_vga_sync_receiver.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_sync_receiver
// Purpose  : Directed bench for vga_sync_receiver using a reduced video mode
//            (20x12 total, 12x6 active) so many frames fit in a short run.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_sync_receiver;

    localparam int TH  = 20;
    localparam int THS = 3;
    localparam int THB = 2;
    localparam int THA = 12;
    localparam int TV  = 12;
    localparam int TVS = 2;
    localparam int TVB = 2;
    localparam int TVA = 6;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pix_ce = 1'b0;
    logic        vga_hs = 1'b1;
    logic        vga_vs = 1'b1;
    logic [3:0]  vga_r = '0, vga_g = '0, vga_b = '0;
    logic        de, frame_start, locked;
    logic [9:0]  px_x, px_y;
    logic [11:0] px_rgb;
    logic [7:0]  err_cnt;
`ifdef VGA_RX_CRC_EN
    logic [15:0] frame_crc;
    logic        crc_valid;
`endif

    int tests = 0;
    int fails = 0;

    // Per-pixel observation state
    logic exp_lock = 1'b0;
    logic chk_en   = 1'b1;
    int   de_errs  = 0;
    int   de_cnt   = 0;
    int   fs_cnt   = 0;
    logic seen_first = 1'b0;
    int   first_x = -1, first_y = -1, max_x = 0, max_y = 0;

    vga_sync_receiver #(
        .H_TOTAL(TH), .H_SYNC(THS), .H_BACK(THB), .H_ACTIVE(THA),
        .V_TOTAL(TV), .V_SYNC(TVS), .V_BACK(TVB), .V_ACTIVE(TVA),
        .LOCK_FRAMES(2)
    ) dut (
        .clk(clk), .rst(rst), .pix_ce(pix_ce),
        .vga_hs(vga_hs), .vga_vs(vga_vs),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .de(de), .px_x(px_x), .px_y(px_y), .px_rgb(px_rgb),
        .frame_start(frame_start), .locked(locked), .err_cnt(err_cnt)
`ifdef VGA_RX_CRC_EN
        , .frame_crc(frame_crc), .crc_valid(crc_valid)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One pixel sample: pix_ce high for one clk, then low for one clk.
    task automatic send_pixel(input int l, input int p, input logic hs, input logic vs);
        logic [11:0] rgb;
        logic        exp_de;
        rgb = {4'(p), 4'(l), 4'hA};
        @(negedge clk);
        pix_ce = 1'b1;
        vga_hs = hs;
        vga_vs = vs;
        {vga_r, vga_g, vga_b} = rgb;
        @(negedge clk);
        pix_ce = 1'b0;
        exp_de = exp_lock && (p >= THS + THB) && (p < THS + THB + THA) &&
                 (l >= TVS + TVB) && (l < TVS + TVB + TVA);
        if (frame_start === 1'b1) fs_cnt++;
        if (de === 1'b1) begin
            de_cnt++;
            if (!seen_first) begin
                seen_first = 1'b1;
                first_x = int'(px_x);
                first_y = int'(px_y);
            end
            if (int'(px_x) > max_x) max_x = int'(px_x);
            if (int'(px_y) > max_y) max_y = int'(px_y);
            if (px_x !== 10'(p - (THS + THB)) || px_y !== 10'(l - (TVS + TVB)) || px_rgb !== rgb)
                de_errs++;
        end
        if (chk_en && de !== exp_de) de_errs++;
    endtask

    task automatic send_line(input int l, input int len, input int hsw, input int p0);
        for (int p = p0; p < len; p++) begin
            send_pixel(l, p, (p < hsw) ? 1'b0 : 1'b1, (l < TVS) ? 1'b0 : 1'b1);
        end
    endtask

    task automatic send_lines(input int l0, input int l1);
        for (int l = l0; l < l1; l++) send_line(l, TH, THS, 0);
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_de", 32'(de), 0);
        check("rst_locked", 32'(locked), 0);
        check("rst_err_cnt", 32'(err_cnt), 0);
        check("rst_frame_start", 32'(frame_start), 0);
        check("rst_px_x", 32'(px_x), 0);
        check("rst_px_rgb", 32'(px_rgb), 0);
        rst = 1'b0;

        // Two acquisition frames, lock on the third vsync edge
        exp_lock = 1'b0;
        send_lines(0, TV);
        send_lines(0, TV);
        check("pre_lock_locked", 32'(locked), 0);
        check("pre_lock_fs_cnt", 32'(fs_cnt), 2);
        check("pre_lock_err", 32'(err_cnt), 0);

        de_cnt = 0; seen_first = 1'b0; max_x = 0; max_y = 0;
        exp_lock = 1'b1;
        send_lines(0, TV);
        check("lock_locked", 32'(locked), 1);
        check("lock_de_cnt", 32'(de_cnt), THA * TVA);
        check("lock_first_x", 32'(first_x), 0);
        check("lock_first_y", 32'(first_y), 0);
        check("lock_max_x", 32'(max_x), THA - 1);
        check("lock_max_y", 32'(max_y), TVA - 1);
        check("lock_hold_px_x", 32'(px_x), THA - 1);
        check("lock_hold_px_y", 32'(px_y), TVA - 1);
        check("lock_err_cnt", 32'(err_cnt), 0);
        check("lock_de_errs", 32'(de_errs), 0);

        // Short line while locked: detected at the next hs falling edge
        send_lines(0, 4);
        send_line(4, TH - 1, THS, 0);
        check("short_still_locked", 32'(locked), 1);
        exp_lock = 1'b0;
        send_pixel(5, 0, 1'b0, 1'b1);
        check("short_unlocked", 32'(locked), 0);
        check("short_err_cnt", 32'(err_cnt), 1);
        send_line(5, TH, THS, 1);
        send_lines(6, TV);
        send_lines(0, TV);
        send_lines(0, TV);
        check("relock_pending", 32'(locked), 0);
        exp_lock = 1'b1;
        send_lines(0, TV);
        check("relock_locked", 32'(locked), 1);
        check("relock_err_cnt", 32'(err_cnt), 1);
        check("relock_de_errs", 32'(de_errs), 0);

        // Timeout: hs stays high far beyond two line periods
        send_lines(0, 4);
        send_line(4, 3 * TH, THS, 0);
        exp_lock = 1'b0;
        check("timeout_locked", 32'(locked), 0);
        check("timeout_err_cnt", 32'(err_cnt), 2);
        send_lines(5, TV);
        check("timeout_de_errs", 32'(de_errs), 0);

        // Narrow hsync during MEASURE prevents lock at the usual frame
        send_lines(0, TV);
        send_lines(0, 3);
        send_line(3, TH, THS - 1, 0);
        send_lines(4, TV);
        send_lines(0, TV);
        check("narrow_hs_locked", 32'(locked), 0);
        check("narrow_hs_err_cnt", 32'(err_cnt), 2);
        check("narrow_hs_de_errs", 32'(de_errs), 0);

        // Reset mid-frame
        chk_en = 1'b0;
        send_lines(0, TV);
        send_lines(0, 4);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_de", 32'(de), 0);
        check("mid_rst_locked", 32'(locked), 0);
        check("mid_rst_err_cnt", 32'(err_cnt), 0);
        check("mid_rst_px_x", 32'(px_x), 0);
        check("mid_rst_px_y", 32'(px_y), 0);
        check("mid_rst_px_rgb", 32'(px_rgb), 0);
        check("mid_rst_frame_start", 32'(frame_start), 0);
        rst = 1'b0;
        chk_en = 1'b1;
        send_lines(4, TV);
        send_lines(0, TV);
        send_lines(0, TV);
        check("post_rst_pending", 32'(locked), 0);
        de_cnt = 0;
        exp_lock = 1'b1;
        send_lines(0, TV);
        check("post_rst_locked", 32'(locked), 1);
        check("post_rst_err_cnt", 32'(err_cnt), 0);
        check("post_rst_de_cnt", 32'(de_cnt), THA * TVA);
        check("post_rst_de_errs", 32'(de_errs), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
